// File: rtl/spi_instr_decoder.sv
// Command/data protocol decoder between the SPI byte bridge and the PWM register file.
// Turns received bytes into single-cycle register read/write strobes and returns read data.
module spi_instr_decoder #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              byte_sync,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_read,
   output logic [7:0]        data_write
);

   typedef enum logic {
      ST_CMD  = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                rw_q, rw_d;
   logic                burst_q, burst_d;
   logic                inc_q, inc_d;
   logic                read_d, write_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [7:0]          data_write_d, data_out_d;
   logic                abort;

   // Chip select released with no byte completing: drop the whole transaction context.
   assign abort = cs_n && !byte_sync;

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      burst_d      = burst_q;
      inc_d        = 1'b0;
      read_d       = 1'b0;
      write_d      = 1'b0;
      addr_d       = addr;
      data_write_d = data_write;
      data_out_d   = read ? data_read : data_out;

      // Post-write address bump lands one cycle after the write strobe
      if (inc_q && !abort) begin
         addr_d = addr + ADDR_W'(1);
      end

      unique case (state_q)
         ST_CMD: begin
            if (byte_sync && !cs_n) begin
               rw_d    = data_in[7];
               burst_d = data_in[6];
               addr_d  = ADDR_W'(data_in[5:0]);
               read_d  = !data_in[7];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (byte_sync) begin
               if (rw_q) begin
                  write_d      = 1'b1;
                  data_write_d = data_in;
                  inc_d        = burst_q;
               end else if (burst_q) begin
                  addr_d = addr + ADDR_W'(1);
                  read_d = 1'b1;
               end
               if (!burst_q) begin
                  state_d = ST_CMD;
               end
            end
         end
         default: state_d = ST_CMD;
      endcase

      if (abort) begin
         state_d = ST_CMD;
         rw_d    = 1'b0;
         burst_d = 1'b0;
         inc_d   = 1'b0;
         read_d  = 1'b0;
         write_d = 1'b0;
      end else if (cs_n) begin
         state_d = ST_CMD;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CMD;
         rw_q       <= 1'b0;
         burst_q    <= 1'b0;
         inc_q      <= 1'b0;
         read       <= 1'b0;
         write      <= 1'b0;
         addr       <= '0;
         data_write <= 8'h00;
         data_out   <= 8'h00;
      end else begin
         state_q    <= state_d;
         rw_q       <= rw_d;
         burst_q    <= burst_d;
         inc_q      <= inc_d;
         read       <= read_d;
         write      <= write_d;
         addr       <= addr_d;
         data_write <= data_write_d;
         data_out   <= data_out_d;
      end
   end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: a small register file model plus strobe logging.
module tb_spi_instr_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs_n;
   logic       byte_sync;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic [7:0] data_read;
   logic [7:0] data_write;

   logic [7:0] mem [64];
   logic [5:0] wr_addr [$];
   logic [7:0] wr_data [$];
   logic [5:0] rd_addr [$];
   int         both_hi = 0;
   int         passes  = 0;
   int         total   = 0;

   always #5 clk = ~clk;

   assign data_read = mem[addr];

   spi_instr_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .byte_sync  (byte_sync),
      .data_in    (data_in),
      .data_out   (data_out),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .data_read  (data_read),
      .data_write (data_write)
   );

   // Strobe log, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (write) begin
            wr_addr.push_back(addr);
            wr_data.push_back(data_write);
         end
         if (read) rd_addr.push_back(addr);
         if (read && write) both_hi++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Byte in cycle N; returns at the negedge of cycle N+1
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data_in   = b;
      byte_sync = 1'b1;
      @(negedge clk);
      byte_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      wr_addr.delete();
      wr_data.delete();
      rd_addr.delete();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[10]   = 8'hA7;
      mem[3]    = 8'h01;
      mem[4]    = 8'h02;
      mem[6'h21] = 8'h6E;
      mem[6'h37] = 8'hC3;

      rst_n = 1'b0; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
      idle(3);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_strobes", {30'd0, read, write}, 32'h0);
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_data_write", 32'(data_write), 32'h00);
      rst_n = 1'b1;
      idle(2);

      // Single write followed, in the same frame, by a single read
      cs_n = 1'b0;
      clear_logs();
      send_byte(8'h85);
      idle(1);
      send_byte(8'h3C);
      check("wr_strobe", 32'(write), 32'h1);
      check("wr_addr", 32'(addr), 32'h05);
      check("wr_data", 32'(data_write), 32'h3C);
      idle(2);
      check("wr_count", 32'(wr_addr.size()), 32'd1);
      check("wr_no_read", 32'(rd_addr.size()), 32'd0);
      check("wr_hold_data", 32'(data_write), 32'h3C);
      clear_logs();
      send_byte(8'h0A);
      check("rd_strobe", 32'(read), 32'h1);
      check("rd_addr", 32'(addr), 32'h0A);
      idle(1);
      check("rd_one_cycle", 32'(read), 32'h0);
      check("rd_data_out", 32'(data_out), 32'hA7);
      send_byte(8'hFF);
      check("rd_dummy_no_read", 32'(read), 32'h0);
      check("rd_data_stable", 32'(data_out), 32'hA7);
      idle(2);
      cs_n = 1'b1;
      idle(2);
      check("rd_count", 32'(rd_addr.size()), 32'd1);
      check("rd_no_write", 32'(wr_addr.size()), 32'd0);
      check("rd_data_held_cs", 32'(data_out), 32'hA7);

      // Burst write wrapping 62 -> 63 -> 0
      cs_n = 1'b0;
      clear_logs();
      send_byte(8'hFE);
      idle(1);
      send_byte(8'h11);
      idle(1);
      send_byte(8'h22);
      idle(1);
      send_byte(8'h33);
      idle(2);
      cs_n = 1'b1;
      idle(2);
      check("bw_count", 32'(wr_addr.size()), 32'd3);
      check("bw_a0", 32'(wr_addr[0]), 32'd62);
      check("bw_d0", 32'(wr_data[0]), 32'h11);
      check("bw_a1", 32'(wr_addr[1]), 32'd63);
      check("bw_d1", 32'(wr_data[1]), 32'h22);
      check("bw_a2", 32'(wr_addr[2]), 32'd0);
      check("bw_d2", 32'(wr_data[2]), 32'h33);
      check("bw_final_addr", 32'(addr), 32'd1);
      check("bw_no_read", 32'(rd_addr.size()), 32'd0);

      // Burst read of registers 3, 4
      cs_n = 1'b0;
      clear_logs();
      send_byte(8'h43);
      check("br_addr0", 32'(addr), 32'd3);
      check("br_read0", 32'(read), 32'h1);
      idle(1);
      check("br_dout0", 32'(data_out), 32'h01);
      send_byte(8'h00);
      check("br_addr1", 32'(addr), 32'd4);
      check("br_read1", 32'(read), 32'h1);
      idle(1);
      check("br_dout1", 32'(data_out), 32'h02);
      idle(1);
      cs_n = 1'b1;
      idle(2);
      check("br_count", 32'(rd_addr.size()), 32'd2);
      check("br_no_write", 32'(wr_addr.size()), 32'd0);

      // Abort before the data byte, then a clean write
      cs_n = 1'b0;
      clear_logs();
      send_byte(8'h90);
      idle(1);
      cs_n = 1'b1;
      idle(2);
      cs_n = 1'b0;
      send_byte(8'h81);
      idle(1);
      send_byte(8'h55);
      idle(2);
      cs_n = 1'b1;
      idle(2);
      check("ab_count", 32'(wr_addr.size()), 32'd1);
      check("ab_addr", 32'(wr_addr[0]), 32'd1);
      check("ab_data", 32'(wr_data[0]), 32'h55);

      // Back-to-back sync: dummy byte immediately after a read command
      cs_n = 1'b0;
      clear_logs();
      @(negedge clk);
      data_in = 8'h21; byte_sync = 1'b1;
      @(negedge clk);
      data_in = 8'hEE;
      check("b2b_read", 32'(read), 32'h1);
      check("b2b_addr", 32'(addr), 32'h21);
      @(negedge clk);
      byte_sync = 1'b0;
      check("b2b_dout", 32'(data_out), 32'h6E);
      idle(2);
      cs_n = 1'b1;
      idle(2);
      check("b2b_rd_count", 32'(rd_addr.size()), 32'd1);
      check("b2b_no_write", 32'(wr_addr.size()), 32'd0);

      // Reset mid-write; the following byte becomes a command
      cs_n = 1'b0;
      send_byte(8'h82);
      idle(1);
      rst_n = 1'b0;
      #1;
      check("mr_data_out", 32'(data_out), 32'h00);
      check("mr_addr", 32'(addr), 32'h0);
      check("mr_data_write", 32'(data_write), 32'h00);
      idle(1);
      rst_n = 1'b1;
      clear_logs();
      idle(1);
      send_byte(8'h77);
      check("mr_read", 32'(read), 32'h1);
      check("mr_read_addr", 32'(addr), 32'h37);
      idle(1);
      check("mr_dout", 32'(data_out), 32'hC3);
      idle(2);
      cs_n = 1'b1;
      idle(2);
      check("mr_no_write", 32'(wr_addr.size()), 32'd0);
      check("never_both", 32'(both_hi), 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/spi_instr_decoder.md
Name: spi_instr_decoder

Overview:
- Sits directly downstream of the SPI byte bridge in the PWM generator's register path.
- Consumes each received byte (`data_in` qualified by `byte_sync`) and interprets it as a command/data protocol.
- Drives single-cycle read/write strobes into the PWM register file.
- Returns read data to the bridge on `data_out`, which the bridge shifts out on MISO during the following byte.

Parameters:
- ADDR_W, 6, register address width; fixed at 6 because the command byte carries a 6-bit address.

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  asynchronous active-low reset
- cs_n  input  1  SPI chip select (active low), same signal the bridge sees; used for transaction framing
- byte_sync  input  1  one-cycle pulse from the bridge: `data_in` holds a complete byte
- data_in  input  8  received byte
- data_out  output  8  byte to shift out on MISO during the next transfer
- read  output  1  one-cycle register read strobe
- write  output  1  one-cycle register write strobe
- addr  output  ADDR_W  register address for `read`/`write`
- data_read  input  8  register file read data, combinational from `addr`, valid in the cycle `read`=1
- data_write  output  8  write data, valid while `write`=1

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to CMD.
  - `data_out`=0x00, `read`=0, `write`=0, `addr`=0, `data_write`=0x00.
  - Internal rw and burst flags are cleared.
  - Reset mid-transaction discards everything; no strobe is issued.
- All outputs are registered. `read` and `write` are never high in the same cycle and never high for more than one cycle per event.
- Command byte format:
  - bit7: rw (1=write, 0=read).
  - bit6: burst (1=auto-increment address after each data byte).
  - bits5:0: address.
- State CMD (waiting for command):
  - On `byte_sync` with `cs_n`=0: latch rw, burst, and addr=data_in[5:0], then go to DATA.
  - If rw=0, pulse `read`=1 in the next cycle (N+1) with the new `addr`. Sample `data_read` at that edge so `data_out` is updated in cycle N+2.
  - If rw=1, issue no strobe.
- State DATA (waiting for data byte):
  - On `byte_sync` at cycle M with rw=1: in cycle M+1, `write`=1 and `data_write`=data_in, with `addr` unchanged.
  - On `byte_sync` at cycle M with rw=0: `data_in` is ignored (dummy byte; the master has just clocked out `data_out`).
  - Non-burst: return to CMD after the data byte.
  - Burst write: at M+2, `addr`=addr+1 (modulo 64, so 63→0). Remain in DATA.
  - Burst read: at M+1, `addr`=addr+1 (wrapping) and `read`=1; at M+2, `data_out`=data_read for the new address. Remain in DATA.
  - A burst ends only when `cs_n` goes high.
- `cs_n` framing:
  - `cs_n`=1 with no `byte_sync` in the same cycle: state goes to CMD next cycle. Any pending rw/burst context is dropped and no strobe is generated.
  - `cs_n`=1 in the same cycle as `byte_sync`: the byte is processed normally (a final write still completes), then state is forced to CMD.
  - `data_out` holds its last value across `cs_n` toggles; it is changed only by read capture or reset.
- `byte_sync` in the cycle immediately after a command byte (back-to-back sync): handled normally; the pending `read` strobe is still issued.
- `data_write` and `addr` hold their values when idle. They are not cleared after strobes.

Test Plan:
- Single write: cmd 0x85 then 0x3C, `cs_n`=0 → exactly one `write` pulse with `addr`=5, `data_write`=0x3C; state returns to CMD; `read` never asserted.
- Single read: register 0x0A=0xA7; cmd 0x0A → `read` pulse with `addr`=0x0A one cycle after `byte_sync`; `data_out`=0xA7 one cycle later and stable through the dummy byte; no `write` pulse.
- Burst write with wrap: cmd 0xFE, then 0x11, 0x22, 0x33 → writes to addresses 62, 63, 0 with data 0x11, 0x22, 0x33; raise `cs_n` → CMD.
- Burst read: regs 3=0x01, 4=0x02; cmd 0x43, dummy byte → `read` at addr 3, then at addr 4; `data_out` sequence is 0x01 then 0x02.
- Abort: cmd 0x90, then `cs_n` high before the data byte; next cmd 0x81 with data 0x55 → write only to addr 1 with data 0x55; addr 0x10 is never written.
- Reset mid-write: assert `rst_n`=0 after cmd 0x82 → all outputs 0; after release, data byte 0x77 is treated as a command (read of addr 0x37); no `write` pulse.
